burst_mem_model: RTL and testbench

BURST_MEM_MODEL -- requirements
Module: burst_mem_model

---
 rtl/burst_mem_model.sv | 188 ++++++++++++++++++
 tb/tb_burst_mem_model.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/burst_mem_model.sv
// Burst memory model behind a request/ack/response handshake with configurable latency and wrapping.
// Defining BURST_MEM_PROTO_CHECK_EN compiles in a sticky protocol-violation checker driving proto_err.
module burst_mem_model #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int BURSTS   = 4,
    parameter int ACK_LAT  = 1,
    parameter int RESP_LAT = 1,
    parameter int WRAP     = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dfp_read,
    input  logic              dfp_write,
    input  logic [DATA_W-1:0] dfp_wdata,
    output logic              dfp_ack,
    output logic              dfp_resp,
    output logic [DATA_W-1:0] dfp_rdata,
    output logic              proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int K  = $clog2(DATA_W / 8);
    localparam logic [3:0] ACK_LAST   = (ACK_LAT == 0)  ? 4'd0 : 4'(ACK_LAT - 1);
    localparam logic [3:0] RESP_LAST  = (RESP_LAT == 0) ? 4'd0 : 4'(RESP_LAT - 1);
    localparam logic [3:0] BURST_LAST = 4'(BURSTS - 1);
    localparam logic [AW-1:0] WRAP_MASK = AW'(BURSTS - 1);

    typedef enum logic [2:0] {IDLE, ACKW, ACK, ADDR, WDATA, RWAIT, RHDR, RDATA} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              is_read_q, is_read_d;
    logic [AW-1:0]     base_q, base_d;
    logic              oor_q, oor_d;
    logic [DATA_W-1:0] byte_addr_q, byte_addr_d;
    logic              ack_q, resp_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Wrapping bursts keep the burst-aligned upper bits and roll only the low index bits.
    function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] base, input logic [3:0] idx);
        logic [AW-1:0] inc;
        inc = base + AW'(idx);
        if (WRAP != 0) beat_addr = (base & ~WRAP_MASK) | (inc & WRAP_MASK);
        else           beat_addr = inc;
    endfunction

    // Next-state, counter and address-capture logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_read_d   = is_read_q;
        base_d      = base_q;
        oor_d       = oor_q;
        byte_addr_d = byte_addr_q;
        case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                if (dfp_read || dfp_write) begin
                    is_read_d = dfp_read;
                    state_d   = (ACK_LAT == 0) ? ACK : ACKW;
                end else begin
                    state_d = IDLE;
                end
            end
            ACKW: begin
                if (cnt_q == ACK_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ACK:   state_d = ADDR;
            ADDR: begin
                cnt_d       = 4'd0;
                byte_addr_d = dfp_wdata;
                base_d      = dfp_wdata[AW+K-1:K];
                oor_d       = |dfp_wdata[DATA_W-1:AW+K];
                if (!is_read_q)         state_d = WDATA;
                else if (RESP_LAT == 0) state_d = RHDR;
                else                    state_d = RWAIT;
            end
            RWAIT: begin
                if (cnt_q == RESP_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = RHDR;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RHDR: begin
                cnt_d   = 4'd0;
                state_d = RDATA;
            end
            WDATA, RDATA: begin
                if (cnt_q == BURST_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = IDLE;
            end
        endcase
    end

    // The memory word for the coming beat is fetched at the edge that starts it, so beats run gap-free.
    always_comb begin
        rdata_d = '0;
        if (state_d == RHDR)                rdata_d = byte_addr_d;
        else if (state_d == RDATA && !oor_d) rdata_d = mem_q[beat_addr(base_d, cnt_d)];
        else                                 rdata_d = '0;
    end

    // Control state and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            is_read_q   <= 1'b0;
            base_q      <= '0;
            oor_q       <= 1'b0;
            byte_addr_q <= '0;
            ack_q       <= 1'b0;
            resp_q      <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_read_q   <= is_read_d;
            base_q      <= base_d;
            oor_q       <= oor_d;
            byte_addr_q <= byte_addr_d;
            ack_q       <= (state_d == ACK);
            resp_q      <= (state_d == RHDR) || (state_d == RDATA);
            rdata_q     <= rdata_d;
        end
    end

    // Memory array has no reset so its contents survive an aborted transaction.
    always_ff @(posedge clk) begin
        if (state_q == WDATA && !oor_q) mem_q[beat_addr(base_q, cnt_q)] <= dfp_wdata;
    end

    assign dfp_ack   = ack_q;
    assign dfp_resp  = resp_q;
    assign dfp_rdata = rdata_q;

`ifdef BURST_MEM_PROTO_CHECK_EN
    logic err_q;
    logic viol_s;
    logic wdata_x_s;

`ifndef SYNTHESIS
    assign wdata_x_s = $isunknown(dfp_wdata);
`else
    assign wdata_x_s = 1'b0;
`endif

    // Violation decode per state; an active request must stay asserted until acknowledged.
    always_comb begin
        viol_s = 1'b0;
        case (state_q)
            IDLE:                       viol_s = dfp_read & dfp_write;
            ACKW, ACK:                  viol_s = is_read_q ? ~dfp_read : ~dfp_write;
            ADDR:                       viol_s = dfp_read | dfp_write | wdata_x_s;
            WDATA, RWAIT, RHDR, RDATA:  viol_s = dfp_read | dfp_write;
            default:                    viol_s = 1'b0;
        endcase
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_q | viol_s;
    end

    assign proto_err = err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_burst_mem_model.sv
// Directed bench: default instance (index 0) and a WRAP=1 zero-latency instance (index 1).
module tb_burst_mem_model;

`ifdef BURST_MEM_PROTO_CHECK_EN
    localparam bit PC = 1'b1;
`else
    localparam bit PC = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        rd    [2];
    logic        wr    [2];
    logic [31:0] wdata [2];
    logic        ack   [2];
    logic        resp  [2];
    logic [31:0] rdata [2];
    logic        perr  [2];
    int          errors;
    int          checks;

    burst_mem_model dut0 (
        .clk(clk), .rst_n(rst_n), .dfp_read(rd[0]), .dfp_write(wr[0]), .dfp_wdata(wdata[0]),
        .dfp_ack(ack[0]), .dfp_resp(resp[0]), .dfp_rdata(rdata[0]), .proto_err(perr[0])
    );

    burst_mem_model #(.DATA_W(32), .DEPTH(1024), .BURSTS(4), .ACK_LAT(0), .RESP_LAT(0), .WRAP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .dfp_read(rd[1]), .dfp_write(wr[1]), .dfp_wdata(wdata[1]),
        .dfp_ack(ack[1]), .dfp_resp(resp[1]), .dfp_rdata(rdata[1]), .proto_err(perr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction; m selects which read beats have a defined expectation.
    task automatic xact(input int d, input bit is_rd, input logic [31:0] addr,
                        input logic [3:0][31:0] dat, input logic [3:0] m,
                        input int alat, input int rlat, input bit poke, input string tag);
        if (is_rd) rd[d] = 1'b1;
        else       wr[d] = 1'b1;
        for (int i = 0; i < alat; i++) begin
            tick();
            chk({tag, ".ackw"}, {31'd0, ack[d]}, 32'd0);
        end
        tick();
        chk({tag, ".ack"}, {31'd0, ack[d]}, 32'd1);
        tick();
        rd[d] = 1'b0;
        wr[d] = 1'b0;
        wdata[d] = addr;
        chk({tag, ".ack_done"}, {31'd0, ack[d]}, 32'd0);
        if (!is_rd) begin
            for (int i = 0; i < 4; i++) begin
                tick();
                wdata[d] = dat[i];
            end
            tick();
            wdata[d] = 32'd0;
            chk({tag, ".wr_noresp"}, {31'd0, resp[d]}, 32'd0);
        end else begin
            for (int i = 0; i < rlat; i++) begin
                tick();
                wdata[d] = 32'd0;
                chk({tag, ".rwait_resp"}, {31'd0, resp[d]}, 32'd0);
                chk({tag, ".rwait_data"}, rdata[d], 32'd0);
            end
            tick();
            wdata[d] = 32'd0;
            chk({tag, ".hdr_resp"}, {31'd0, resp[d]}, 32'd1);
            chk({tag, ".hdr_data"}, rdata[d], addr);
            for (int i = 0; i < 4; i++) begin
                tick();
                chk($sformatf("%s.beat%0d_resp", tag, i), {31'd0, resp[d]}, 32'd1);
                if (m[i]) chk($sformatf("%s.beat%0d_data", tag, i), rdata[d], dat[i]);
                if (poke && i == 1) rd[d] = 1'b1;
                if (poke && i == 2) begin
                    rd[d] = 1'b0;
                    chk({tag, ".perr_set"}, {31'd0, perr[d]}, {31'd0, PC});
                end
            end
            tick();
            chk({tag, ".end_resp"}, {31'd0, resp[d]}, 32'd0);
            chk({tag, ".end_data"}, rdata[d], 32'd0);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 1'b0;
            wr[d] = 1'b0;
            wdata[d] = 32'd0;
        end
        #2;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst%0d.ack", d), {31'd0, ack[d]}, 32'd0);
            chk($sformatf("rst%0d.resp", d), {31'd0, resp[d]}, 32'd0);
            chk($sformatf("rst%0d.rdata", d), rdata[d], 32'd0);
            chk($sformatf("rst%0d.perr", d), {31'd0, perr[d]}, 32'd0);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Basic write then read, incrementing bursts.
        xact(0, 1'b0, 32'h100, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'hF, 1, 1, 1'b0, "wrA");
        xact(0, 1'b1, 32'h100, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'hF, 1, 1, 1'b0, "rdA");
        // Overlapping write one word up, read back immediately.
        xact(0, 1'b0, 32'h104, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 4'hF, 1, 1, 1'b0, "wrB");
        xact(0, 1'b1, 32'h100, {32'hB2, 32'hB1, 32'hB0, 32'hA0}, 4'hF, 1, 1, 1'b0, "rdAB");
        // Burst crossing the top of memory wraps modulo DEPTH.
        xact(0, 1'b0, 32'hFFC, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 4'hF, 1, 1, 1'b0, "wrC");
        xact(0, 1'b1, 32'hFFC, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 4'hF, 1, 1, 1'b0, "rdC");
        xact(0, 1'b1, 32'h000, {32'h0, 32'hC3, 32'hC2, 32'hC1}, 4'h7, 1, 1, 1'b0, "rdC0");
        // Out-of-range accesses: write dropped, read returns zero beats.
        xact(0, 1'b0, 32'h8000_0100, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 4'hF, 1, 1, 1'b0, "wrOOR");
        xact(0, 1'b1, 32'h8000_0000, {32'h0, 32'h0, 32'h0, 32'h0}, 4'hF, 1, 1, 1'b0, "rdOOR");
        xact(0, 1'b1, 32'h100, {32'hB2, 32'hB1, 32'hB0, 32'hA0}, 4'hF, 1, 1, 1'b0, "rdKeep");
        // Critical-word-first wrapping with zero latencies.
        xact(1, 1'b0, 32'h40, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 4'hF, 0, 0, 1'b0, "wrW");
        xact(1, 1'b1, 32'h48, {32'hE1, 32'hE0, 32'hE3, 32'hE2}, 4'hF, 0, 0, 1'b0, "rdW");
        chk("perr1.clean", {31'd0, perr[1]}, 32'd0);
        // Request raised during the data phase: transaction completes, flag sticks.
        chk("perr0.before", {31'd0, perr[0]}, 32'd0);
        xact(0, 1'b1, 32'h100, {32'hB2, 32'hB1, 32'hB0, 32'hA0}, 4'hF, 1, 1, 1'b1, "rdPoke");
        tick();
        chk("perr0.sticky", {31'd0, perr[0]}, {31'd0, PC});
        chk("poke.idle_ack", {31'd0, ack[0]}, 32'd0);

        // Reset during the second write beat keeps only the first new beat.
        xact(0, 1'b0, 32'h200, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 4'hF, 1, 1, 1'b0, "wrOld");
        wr[0] = 1'b1;
        tick();
        tick();
        chk("abort.ack", {31'd0, ack[0]}, 32'd1);
        tick();
        wr[0] = 1'b0;
        wdata[0] = 32'h200;
        tick();
        wdata[0] = 32'h5A5A_0000;
        tick();
        wdata[0] = 32'h5A5A_0001;
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort.ack0", {31'd0, ack[0]}, 32'd0);
        chk("abort.resp0", {31'd0, resp[0]}, 32'd0);
        chk("abort.rdata0", rdata[0], 32'd0);
        chk("abort.perr0", {31'd0, perr[0]}, 32'd0);
        tick();
        wdata[0] = 32'd0;
        tick();
        rst_n = 1'b1;
        tick();
        xact(0, 1'b1, 32'h200, {32'hF3, 32'hF2, 32'hF1, 32'h5A5A_0000}, 4'hF, 1, 1, 1'b0, "rdAbort");
        chk("final.perr0", {31'd0, perr[0]}, 32'd0);
        chk("final.perr1", {31'd0, perr[1]}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
